// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC responder.
package spi_adc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [BYTE_W-1:0] CMD_READ_SAMPLE = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ_ID     = 8'h02;
  localparam logic [BYTE_W-1:0] DEVICE_ID       = 8'h5A;
  localparam logic [BYTE_W-1:0] DEFAULT_RESP    = 8'hFF;

  // Response byte returned for a given command.
  function automatic logic [BYTE_W-1:0] resp_for_cmd(input logic [BYTE_W-1:0] cmd,
                                                     input logic [BYTE_W-1:0] sample);
    case (cmd)
      CMD_READ_SAMPLE: resp_for_cmd = sample;
      CMD_READ_ID:     resp_for_cmd = DEVICE_ID;
      default:         resp_for_cmd = DEFAULT_RESP;
    endcase
  endfunction

endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI bus lines between a master and the ADC responder.
interface spi_adc_responder_if;
  logic i_spi_clk;
  logic i_spi_cs_n;
  logic i_spi_mosi;
  logic o_spi_miso;

  modport slave  (input  i_spi_clk, i_spi_cs_n, i_spi_mosi, output o_spi_miso);
  modport master (output i_spi_clk, i_spi_cs_n, i_spi_mosi, input  o_spi_miso);
endinterface

// File: rtl/spi_slave_sync.sv
// Synchroniser and edge detector for the three asynchronous SPI inputs.
// SYNC_STAGES is expected to be 2 or 3.
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic cs_fall_c,
  output logic cs_rise_c
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_last_q;
  logic                   cs_last_q;

  // Shift chains preset to the bus idle levels, plus one delayed copy for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_last_q <= 1'b0;
      cs_last_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_last_q <= sclk_q[SYNC_STAGES-1];
      cs_last_q   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign mosi_o      = mosi_q[SYNC_STAGES-1];
  assign sclk_rise_c =  sclk_q[SYNC_STAGES-1] & ~sclk_last_q;
  assign sclk_fall_c = ~sclk_q[SYNC_STAGES-1] &  sclk_last_q;
  assign cs_fall_c   = ~cs_q[SYNC_STAGES-1]   &  cs_last_q;
  assign cs_rise_c   =  cs_q[SYNC_STAGES-1]   & ~cs_last_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave: receives a command byte and answers with an ADC sample,
// the device ID or 0xFF in the second byte of a 16-bit frame.
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] i_sample,
  spi_adc_responder_if.slave spi,
  output logic [BYTE_W-1:0] o_cmd_byte,
  output logic              o_cmd_dv,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic              o_busy
);

  logic mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (spi.i_spi_clk),
    .cs_n_i      (spi.i_spi_cs_n),
    .mosi_i      (spi.i_spi_mosi),
    .mosi_o      (mosi_s),
    .sclk_rise_c (sclk_rise),
    .sclk_fall_c (sclk_fall),
    .cs_fall_c   (cs_fall),
    .cs_rise_c   (cs_rise)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  rx_q, rx_d;
  logic [BYTE_W-1:0]  tx_q, tx_d;
  logic [BYTE_W-1:0]  cmd_byte_q, cmd_byte_d;
  logic               cmd_dv_q, cmd_dv_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               miso_q, miso_d;
  logic               busy_q, busy_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      cmd_byte_q <= '0;
      cmd_dv_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      cmd_byte_q <= cmd_byte_d;
      cmd_dv_q   <= cmd_dv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; a chip-select rise overrides any SCLK edge in the same clk.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    cmd_byte_d = cmd_byte_q;
    cmd_dv_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (cs_rise && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      if (state_q == ST_DONE) done_d = 1'b1;
      else                    err_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            rx_d    = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rx_d  = {rx_q[BYTE_W-2:0], mosi_s};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cmd_byte_d = {rx_q[BYTE_W-2:0], mosi_s};
              cmd_dv_d   = 1'b1;
              tx_d       = resp_for_cmd({rx_q[BYTE_W-2:0], mosi_s}, i_sample);
              state_d    = ST_RESP;
            end
          end
        end
        ST_RESP: begin
          // The falling edge right after the 8th rise precedes the master's first
          // response sample, so tx[7] is held through it rather than shifted out.
          if (sclk_fall && cnt_q != CNT_W'(8)) tx_d = {tx_q[BYTE_W-2:0], 1'b0};
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(15)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end

    miso_d = (state_d == ST_RESP) ? tx_d[BYTE_W-1] : 1'b0;
    busy_d = (state_d == ST_CMD) || (state_d == ST_RESP);
  end

  assign spi.o_spi_miso = miso_q;
  assign o_cmd_byte     = cmd_byte_q;
  assign o_cmd_dv       = cmd_dv_q;
  assign o_frame_done   = done_q;
  assign o_frame_err    = err_q;
  assign o_busy         = busy_q;

endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flip-flop stages synchronising i_spi_clk, i_spi_cs_n and i_spi_mosi; legal range 2..3.
REQ-002 clk  input  1  system clock; the block's only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_sample  input  8  current flex-sensor ADC code, returned on read-sample commands.
REQ-005 i_spi_clk  input  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 i_spi_cs_n  input  1  active-low chip select from the master.
REQ-007 i_spi_mosi  input  1  master-out data line.
REQ-008 o_spi_miso  output  1  slave-out data line.
REQ-009 o_cmd_byte  output  8  last command byte received.
REQ-010 o_cmd_dv  output  1  one-clk pulse when o_cmd_byte updates.
REQ-011 o_frame_done  output  1  one-clk pulse when a complete 16-bit frame ends.
REQ-012 o_frame_err  output  1  one-clk pulse when chip select rises mid-frame.
REQ-013 o_busy  output  1  high while a frame is in progress (state CMD or RESP).

Function
REQ-014 i_spi_clk, i_spi_cs_n and i_spi_mosi shall each pass through SYNC_STAGES flip-flops; SCLK rising/falling edges shall be detected on the synchronised clock, one clk after the synchronised transition.
REQ-015 Supported SCLK frequency shall be at most clk/8; faster operation is out of scope.
REQ-016 A frame shall be 16 SCLK cycles with chip select low: bits 0-7 are the command (MOSI, MSB first); bits 8-15 are the response (MISO, MSB first).
REQ-017 States: IDLE, CMD, RESP, DONE; a 4-bit bit counter shall count SCLK rising edges within the frame.
REQ-018 IDLE->CMD on synchronised chip select falling; bit counter cleared, rx shift register cleared.
REQ-019 In CMD, each SCLK rising edge shall shift synchronised MOSI into the rx register LSB and increment the counter.
REQ-020 On the 8th rising edge: o_cmd_byte <= assembled byte, o_cmd_dv pulses the next clk, tx register loads the response, state->RESP.
REQ-021 Response by command: 0x01 -> i_sample sampled on that clk; 0x02 -> device ID 0x5A; any other value -> 0xFF.
REQ-022 In RESP, o_spi_miso shall equal tx[7]; each SCLK falling edge shall shift tx left by one, zero-filled; rising edges increment the counter.
REQ-023 On the 16th rising edge, state->DONE; o_frame_done pulses when chip select then rises.
REQ-024 In DONE, further SCLK edges are ignored and o_spi_miso = 0.
REQ-025 o_spi_miso shall be 0 in IDLE and CMD.
REQ-026 Chip select rising in CMD or RESP: state->IDLE, o_frame_err pulses one clk, o_cmd_byte unchanged unless the 8th edge had already completed.
REQ-027 Chip select rising on the same clk as an SCLK edge: the chip-select action takes priority and the edge is discarded.
REQ-028 Back-to-back frames: chip select falling detected in the clk after IDLE entry shall start a new frame normally.

Reset
REQ-029 On rst high at a clk rising edge: state IDLE; counter, rx, tx 0; o_spi_miso 0; o_cmd_byte 0x00; o_cmd_dv, o_frame_done, o_frame_err, o_busy 0; synchroniser stages preset to clk=0, cs_n=1, mosi=0.
REQ-030 rst mid-frame shall abort silently, with no o_frame_err; the block then waits for the next chip select falling edge.

Structure
REQ-031 Package spi_adc_pkg shall hold the state enum, the command codes CMD_READ_SAMPLE=0x01 and CMD_READ_ID=0x02, DEVICE_ID=0x5A and the default response 0xFF.
REQ-032 One sub-module, spi_slave_sync, shall hold the synchroniser and edge detector for the three SPI inputs.

Verification
REQ-033 i_sample=0xC3, frame with command 0x01 at SCLK=clk/8 -> MISO bits 8-15 = 0xC3, o_cmd_byte=0x01, one o_cmd_dv pulse, one o_frame_done pulse.
REQ-034 Command 0x02 -> response 0x5A; command 0x7E -> response 0xFF.
REQ-035 Chip select raised after 5 SCLKs -> o_frame_err pulse, no o_cmd_dv, state IDLE; next full 0x01 frame returns i_sample correctly.
REQ-036 i_sample changed from 0x10 to 0x20 after the 8th rising edge -> response is 0x10.
REQ-037 rst asserted during RESP -> all outputs are their reset values the next clk, no o_frame_err; a following frame works.
REQ-038 Two frames with chip select high for 1 SCLK period between them -> both responses correct and two o_frame_done pulses.
